// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - Decode/Execute pipeline register with load-use hazard detection
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [23:0]       CtrlD,
    input  logic [DATA_W-1:0] RD1D,
    input  logic [DATA_W-1:0] RD2D,
    input  logic [DATA_W-1:0] ImmD,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic [REG_AW-1:0] WAddrD,
    input  logic              StallE,
    input  logic              FlushE,
    output logic [23:0]       CtrlE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [DATA_W-1:0] ImmE,
    output logic [REG_AW-1:0] RsE,
    output logic [REG_AW-1:0] RtE,
    output logic [REG_AW-1:0] WAddrE,
    output logic              ValidE,
    output logic              StallF,
    output logic              StallD,
    output logic [CNT_W-1:0]  BubbleCnt
);

    localparam int C_WEWB     = 1;
    localparam int C_MEMTOREG = 20;

    logic [23:0]       r_ctrl;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_imm;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_waddr;
    logic              r_valid;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_lu;
    logic              w_bubble;
    logic [CNT_W-1:0]  w_cnt_inc;

    // Load-use hazard: a valid load in Execute writes a nonzero register that
    // Decode reads on either port; r0 never hazards.
    always_comb begin
        w_lu = r_valid & r_ctrl[C_MEMTOREG] & r_ctrl[C_WEWB] &
               (r_waddr != '0) & ((r_waddr == RsD) | (r_waddr == RtD));
        w_bubble  = FlushE | w_lu;
        w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt
                                             : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign StallF = w_lu | StallE;
    assign StallD = w_lu | StallE;

    // Execute register: reset, hold on StallE, bubble on flush/hazard, else load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl  <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_waddr <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else if (StallE) begin
            r_cnt <= r_cnt;
        end else if (w_bubble) begin
            r_ctrl  <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_waddr <= '0;
            r_valid <= 1'b0;
            r_cnt   <= w_cnt_inc;
        end else begin
            r_ctrl  <= CtrlD;
            r_rd1   <= RD1D;
            r_rd2   <= RD2D;
            r_imm   <= ImmD;
            r_rs    <= RsD;
            r_rt    <= RtD;
            r_waddr <= WAddrD;
            r_valid <= 1'b1;
        end
    end

    assign CtrlE     = r_ctrl;
    assign RD1E      = r_rd1;
    assign RD2E      = r_rd2;
    assign ImmE      = r_imm;
    assign RsE       = r_rs;
    assign RtE       = r_rt;
    assign WAddrE    = r_waddr;
    assign ValidE    = r_valid;
    assign BubbleCnt = r_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - randomized and directed self-checking bench for id_ex_stage_reg
module tb_id_ex_stage_reg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [23:0]   CtrlD;
    logic [DW-1:0] RD1D, RD2D, ImmD;
    logic [AW-1:0] RsD, RtD, WAddrD;
    logic          StallE, FlushE;
    logic [23:0]   CtrlE;
    logic [DW-1:0] RD1E, RD2E, ImmE;
    logic [AW-1:0] RsE, RtE, WAddrE;
    logic          ValidE, StallF, StallD;
    logic [CW-1:0] BubbleCnt;

    id_ex_stage_reg #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D), .ImmD(ImmD),
        .RsD(RsD), .RtD(RtD), .WAddrD(WAddrD),
        .StallE(StallE), .FlushE(FlushE),
        .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E), .ImmE(ImmE),
        .RsE(RsE), .RtE(RtE), .WAddrE(WAddrE),
        .ValidE(ValidE), .StallF(StallF), .StallD(StallD),
        .BubbleCnt(BubbleCnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model of what Execute holds: the instruction in flight (or nothing) and
    // the number of bubbles seen so far.
    bit [23:0]   m_ctrl;
    bit [DW-1:0] m_rd1, m_rd2, m_imm;
    bit [AW-1:0] m_rs, m_rt, m_wa;
    bit          m_valid;
    int          m_cnt;

    function automatic bit model_hazard();
        bit is_load;
        is_load = m_ctrl[20] && m_ctrl[1];
        return m_valid && is_load && (m_wa != 0) && (m_wa == RsD || m_wa == RtD);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_ctrl = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
            m_rs = 0; m_rt = 0; m_wa = 0; m_valid = 0; m_cnt = 0;
        end else if (StallE) begin
            // Execute busy: everything holds.
        end else if (FlushE || model_hazard()) begin
            m_ctrl = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
            m_rs = 0; m_rt = 0; m_wa = 0; m_valid = 0;
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end else begin
            m_ctrl = CtrlD; m_rd1 = RD1D; m_rd2 = RD2D; m_imm = ImmD;
            m_rs = RsD; m_rt = RtD; m_wa = WAddrD; m_valid = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("CtrlE", 64'(CtrlE), 64'(m_ctrl));
            chk("RD1E", 64'(RD1E), 64'(m_rd1));
            chk("RD2E", 64'(RD2E), 64'(m_rd2));
            chk("ImmE", 64'(ImmE), 64'(m_imm));
            chk("RsE", 64'(RsE), 64'(m_rs));
            chk("RtE", 64'(RtE), 64'(m_rt));
            chk("WAddrE", 64'(WAddrE), 64'(m_wa));
            chk("ValidE", 64'(ValidE), 64'(m_valid));
            chk("BubbleCnt", 64'(BubbleCnt), 64'(m_cnt));
            chk("StallF", 64'(StallF), 64'(model_hazard() || StallE));
            chk("StallD", 64'(StallD), 64'(model_hazard() || StallE));
        end
    end

    task automatic apply(input bit r, input bit [23:0] c, input int a, input int b,
                         input int rs, input int rt, input int wa,
                         input bit st, input bit fl);
        @(posedge clk);
        #1;
        rst = r; CtrlD = c; RD1D = DW'(a); RD2D = DW'(b); ImmD = $urandom();
        RsD = AW'(rs); RtD = AW'(rt); WAddrD = AW'(wa); StallE = st; FlushE = fl;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #2;
    endtask

    localparam bit [23:0] ADD = 24'h08000F;
    localparam bit [23:0] LW  = 24'h100A0F;
    localparam bit [23:0] NOP = 24'h000000;

    int sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        rst = 1'b1; CtrlD = $urandom(); RD1D = $urandom(); RD2D = $urandom();
        ImmD = $urandom(); RsD = $urandom(); RtD = $urandom(); WAddrD = $urandom();
        StallE = 1'b0; FlushE = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        apply(1, $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), 0, 0);
        at_neg();
        chk("rst ValidE", 64'(ValidE), 0);
        chk("rst CtrlE", 64'(CtrlE), 0);
        chk("rst BubbleCnt", 64'(BubbleCnt), 0);

        // Pass-through
        apply(0, ADD, 5, 7, 1, 2, 3, 0, 0);
        at_neg();
        chk("rst StallF", 64'(StallF), 0);
        apply(0, NOP, 0, 0, 0, 0, 0, 0, 0);
        at_neg();
        chk("pass CtrlE", 64'(CtrlE), 64'h08000F);
        chk("pass RD1E", 64'(RD1E), 5);
        chk("pass RD2E", 64'(RD2E), 7);
        chk("pass WAddrE", 64'(WAddrE), 3);
        chk("pass ValidE", 64'(ValidE), 1);

        // Load-use on Rs
        apply(0, LW, 0, 0, 1, 0, 4, 0, 0);
        apply(0, ADD, 11, 12, 4, 2, 5, 0, 0);
        at_neg();
        chk("lu StallF", 64'(StallF), 1);
        chk("lu StallD", 64'(StallD), 1);
        apply(0, ADD, 11, 12, 4, 2, 5, 0, 0);
        at_neg();
        chk("lu bubble CtrlE", 64'(CtrlE), 0);
        chk("lu bubble ValidE", 64'(ValidE), 0);
        chk("lu BubbleCnt", 64'(BubbleCnt), 1);
        chk("lu released StallF", 64'(StallF), 0);
        apply(0, NOP, 0, 0, 0, 0, 0, 0, 0);
        at_neg();
        chk("lu add CtrlE", 64'(CtrlE), 64'h08000F);
        chk("lu add RsE", 64'(RsE), 4);

        // r0 load and non-load producer never stall
        apply(0, LW, 0, 0, 1, 1, 0, 0, 0);
        apply(0, ADD, 1, 1, 0, 0, 6, 0, 0);
        at_neg();
        chk("r0 StallF", 64'(StallF), 0);
        apply(0, ADD, 1, 1, 1, 1, 4, 0, 0);
        apply(0, ADD, 1, 1, 4, 4, 6, 0, 0);
        at_neg();
        chk("nonload StallF", 64'(StallF), 0);

        // StallE hold, flush ignored while stalled
        apply(0, ADD, 9, 8, 1, 2, 6, 0, 0);
        apply(0, LW, 100, 101, 6, 6, 7, 1, 0);
        at_neg();
        chk("stallE StallF", 64'(StallF), 1);
        apply(0, LW, 200, 201, 3, 3, 2, 1, 1);
        at_neg();
        chk("stallE RD1E", 64'(RD1E), 9);
        apply(0, NOP, 300, 301, 1, 1, 1, 1, 0);
        at_neg();
        chk("stallE WAddrE", 64'(WAddrE), 6);
        chk("stallE ValidE", 64'(ValidE), 1);
        apply(0, NOP, 0, 0, 0, 0, 0, 0, 0);

        // Flush and saturation
        apply(1, NOP, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            apply(0, ADD, $urandom(), $urandom(), 1, 2, 3, 0, (i < 5));
            if (i > 0) begin
                at_neg();
                chk("sat BubbleCnt", 64'(BubbleCnt), 64'(sat_exp[i-1]));
                chk("sat CtrlE", 64'(CtrlE), 0);
            end
        end

        // Random traffic, small register space to provoke hazards
        apply(1, NOP, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit [23:0] c;
            c = 24'($urandom());
            if ($urandom_range(0, 1) == 1) c = c | 24'h100002;
            apply(($urandom_range(0, 99) < 2), c, $urandom(), $urandom(),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 10));
        end
        @(negedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Pipeline register between Decode and Execute.
- Captures the 24-bit decode control bundle, operands, immediate and register addresses each cycle, and presents them to the Execute stage.
- Contains the load-use hazard detector: it stalls Fetch and Decode and injects a bubble into Execute.
- Handles an external Execute stall (multi-cycle mpp/pmpxl ops) and an external Execute flush.
- Keeps a saturating count of inserted bubbles for performance debug.

Parameters:
DATA_W, 32, operand/immediate width
REG_AW, 5, register address width
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
CtrlD  in  24  decode control bundle. Bit map: [0] MemRegwbAddr, [1] WeWB, [3:2] PCSrc, [4] SumSrcA, [5] SumSrcB, [6] MultSrc, [7] ASrc, [8] BSrc, [12:9] AluControl, [13] MemAddSrc, [17:14] InstrType, [18] MemWrite, [19] RegSrc, [20] MemtoReg, [21] SetInstr, [22] BranchTaken, [23] ShamtMuxCtrl
RD1D  in  DATA_W  register-file read data A
RD2D  in  DATA_W  register-file read data B
ImmD  in  DATA_W  sign-extended immediate / shamt
RsD  in  REG_AW  source register A
RtD  in  REG_AW  source register B
WAddrD  in  REG_AW  destination register
StallE  in  1  hold Execute register (multi-cycle unit busy)
FlushE  in  1  discard the instruction entering Execute
CtrlE  out  24  registered control bundle
RD1E  out  DATA_W  registered operand A
RD2E  out  DATA_W  registered operand B
ImmE  out  DATA_W  registered immediate
RsE  out  REG_AW  registered Rs
RtE  out  REG_AW  registered Rt
WAddrE  out  REG_AW  registered destination
ValidE  out  1  Execute holds a real instruction
StallF  out  1  hold PC (combinational)
StallD  out  1  hold IF/ID register (combinational)
BubbleCnt  out  CNT_W  saturating bubble counter

Behaviour:
- Reset: on a clock edge with rst=1, all E outputs are 0, ValidE=0 and BubbleCnt=0.
- Bubble definition: CtrlE=0, RD1E/RD2E/ImmE=0, register addresses=0, ValidE=0. A bubble has WeWB=0, MemWrite=0 and BranchTaken=0, so it is architecturally inert.
- Load-use hazard, combinational: LU = ValidE & CtrlE[20] & CtrlE[1] & (WAddrE!=0) & ((WAddrE==RsD) | (WAddrE==RtD)).
- StallF = StallD = LU | StallE.
- Register update priority on each rising edge:
  1. rst
  2. StallE=1: hold all E registers and BubbleCnt. FlushE and LU are ignored this cycle.
  3. FlushE=1: load a bubble and increment BubbleCnt.
  4. LU=1: load a bubble and increment BubbleCnt.
  5. Otherwise: load the D inputs and set ValidE=1.
- FlushE and LU asserted in the same cycle insert one bubble and count once.
- Latency: D inputs appear on E outputs 1 cycle later when there is no stall or bubble.
- Load-use stall lasts exactly 1 cycle. The bubble clears the hazard, so the next cycle LU=0 and the held D instruction advances.
- BubbleCnt saturates at 2^CNT_W-1 and does not wrap.
- Register 0 never triggers a hazard.
- A hazard is detected on either Rs or Rt, independent of the instruction's ASrc/BSrc. A false stall is acceptable; a missed stall is not.
- rst asserted mid-stall wins immediately. StallF/StallD deassert the cycle after reset because ValidE=0.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random D inputs -> all E outputs 0, ValidE=0, BubbleCnt=0, StallF=StallD=0.
- Pass-through: add (CtrlD=24'h08000F), RD1D=5, RD2D=7, WAddrD=3 -> next cycle CtrlE=24'h08000F, RD1E=5, RD2E=7, WAddrE=3, ValidE=1.
- Load-use: lw to r4 (CtrlD=24'h100A0F, WAddrD=4), then add with RsD=4 -> StallF=StallD=1 for 1 cycle, CtrlE=0 and ValidE=0 in the following cycle, BubbleCnt=1. The add then reaches E one cycle later.
- r0 and non-load cases:
  - lw to r0, then use of r0 -> no stall.
  - add to r4, then use of r4 -> no stall.
- StallE hold: StallE=1 for 3 cycles while the D inputs change -> E outputs frozen and StallF=1 throughout. FlushE=1 during StallE is ignored.
- Flush plus saturation, with CNT_W=2: FlushE pulsed 5 times -> BubbleCnt reads 1,2,3,3,3. Each flushed cycle gives CtrlE=0.
